// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared types and constants for the I2C target / APB bank.
//   state_e      - protocol FSM states
//   STATUS_OFS   - APB offset of the STATUS register
//   STAT_*_BIT   - STATUS bit positions
//   ACK / NACK   - SDA level of an acknowledge bit
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_WAIT
    } state_e;

    localparam logic [31:0] STATUS_OFS     = 32'h100;
    localparam int          STAT_BUSY_BIT  = 0;
    localparam int          STAT_WRF_BIT   = 1;
    localparam int          STAT_IRQEN_BIT = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_line_filter.sv
// i2c_slave_line_filter: conditions one open-drain bus line.
//   2-FF synchroniser -> glitch filter (level must persist FILT_LEN cycles)
//   -> single-cycle rise/fall pulses, asserted in the same cycle level_o
//   takes its new value.
// Ports:
//   apb_clk, apb_rstn  clock, async active-low reset (line assumed idle high)
//   line_i             raw line
//   level_o            filtered level
//   rise_o / fall_o    one-cycle filtered edge pulses
module i2c_slave_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic apb_clk,
    input  logic apb_rstn,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q, rise_q, fall_q;

    always_ff @(posedge apb_clk or negedge apb_rstn) begin
        if (!apb_rstn) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // cnt_q counts consecutive cycles the synchronised value has
            // disagreed with the accepted level; any agreement restarts it.
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(FILT_LEN - 1)) begin
                    level_q <= sync_q[1];
                    rise_q  <= sync_q[1];
                    fall_q  <= ~sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_apb_if.sv
// i2c_slave_apb_if: I2C target with a REG_NUM-byte bank shared with an
// APB3 slave port. SCL/SDA are oversampled on apb_clk; SCL is never stretched.
// Ports:
//   apb_clk, apb_rstn            clock, async active-low reset
//   i_apb_*                      APB3 request (psel/penable/pwrite/paddr/pwdata)
//   o_apb_pready/prdata/slverr   APB3 response (zero wait states)
//   i2c_scl                      SCL input
//   i2c_sda                      open-drain SDA (driven 0 or high-Z)
//   o_irq                        wr_flag & irq_en, only with I2C_SLAVE_IRQ_EN
// Optional feature macro: I2C_SLAVE_IRQ_EN (STATUS.irq_en and o_irq).
module i2c_slave_apb_if
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int          REG_NUM   = 16,
    parameter int          FILT_LEN  = 3,
    parameter logic [31:0] BASE_ADDR = 32'h43C1_0000
) (
    input  logic        apb_clk,
    input  logic        apb_rstn,
    input  logic        i_apb_psel,
    input  logic        i_apb_penable,
    input  logic        i_apb_pwrite,
    input  logic [31:0] i_apb_paddr,
    input  logic [31:0] i_apb_pwdata,
    output logic        o_apb_pready,
    output logic [31:0] o_apb_prdata,
    output logic        o_apb_slverr,
    input  logic        i2c_scl,
    inout  wire         i2c_sda
`ifdef I2C_SLAVE_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    localparam int PW = $clog2(REG_NUM);

    logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

    i2c_slave_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .apb_clk(apb_clk), .apb_rstn(apb_rstn), .line_i(i2c_scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));

    i2c_slave_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .apb_clk(apb_clk), .apb_rstn(apb_rstn), .line_i(i2c_sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    state_e        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          oe_q, oe_d;
    // R/W bit while in ADDR_ACK, master's ack bit while in RD_ACK
    logic          bit_q, bit_d;
    logic          i2c_we;
    logic [7:0]    bank_q [REG_NUM];
    logic          wr_flag_q;

    // ---------------- protocol FSM ----------------
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ptr_d    = ptr_q;
        oe_d     = oe_q;
        bit_d    = bit_q;
        i2c_we   = 1'b0;
        if (sda_fall && scl_lvl) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            oe_d     = 1'b0;
        end else if (sda_rise && scl_lvl) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        shreg_d  = {shreg_q[6:0], sda_lvl};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        // byte complete: ACK is driven from this falling edge
                        bitcnt_d = '0;
                        oe_d     = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shreg_q[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                bit_d   = shreg_q[0];
                            end else begin
                                state_d = ST_WAIT;
                                oe_d    = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = shreg_q[PW-1:0];
                            state_d = ST_PTR_ACK;
                        end else begin
                            i2c_we  = 1'b1;
                            ptr_d   = ptr_q + 1'b1;
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = '0;
                        if (state_q == ST_ADDR_ACK && bit_q) begin
                            state_d = ST_RD;
                            shreg_d = bank_q[ptr_q];
                            oe_d    = ~bank_q[ptr_q][7];
                        end else begin
                            state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            oe_d     = 1'b0;
                            ptr_d    = ptr_q + 1'b1;
                            bitcnt_d = '0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            oe_d    = ~shreg_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        bit_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (bit_q == ACK) begin
                            state_d = ST_RD;
                            shreg_d = bank_q[ptr_q];
                            oe_d    = ~bank_q[ptr_q][7];
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge apb_clk or negedge apb_rstn) begin
        if (!apb_rstn) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            ptr_q    <= '0;
            oe_q     <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            ptr_q    <= ptr_d;
            oe_q     <= oe_d;
            bit_q    <= bit_d;
        end
    end

    assign i2c_sda = oe_q ? 1'b0 : 1'bz;

    // ---------------- APB decode ----------------
    logic [31:0]   offset;
    logic          bank_hit, stat_hit, apb_we;
    logic [PW-1:0] apb_idx;
    logic          irq_en_q;

    assign offset   = i_apb_paddr - BASE_ADDR;
    assign bank_hit = (offset < 32'(4 * REG_NUM)) && (offset[1:0] == 2'b00);
    assign stat_hit = (offset == STATUS_OFS);
    assign apb_idx  = offset[PW+1:2];
    assign apb_we   = i_apb_psel & i_apb_penable & i_apb_pwrite;

    assign o_apb_pready = 1'b1;
    assign o_apb_slverr = i_apb_psel & ~(bank_hit | stat_hit);

    always_comb begin
        o_apb_prdata = '0;
        if (i_apb_psel) begin
            if (bank_hit) begin
                o_apb_prdata[7:0] = bank_q[apb_idx];
            end else if (stat_hit) begin
                o_apb_prdata[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
                o_apb_prdata[STAT_WRF_BIT]   = wr_flag_q;
                o_apb_prdata[STAT_IRQEN_BIT] = irq_en_q;
            end
        end
    end

    // ---------------- bank and STATUS ----------------
    always_ff @(posedge apb_clk or negedge apb_rstn) begin
        if (!apb_rstn) begin
            for (int n = 0; n < REG_NUM; n++) bank_q[n] <= '0;
            wr_flag_q <= 1'b0;
        end else begin
            // I2C write takes priority over an APB write to the same byte
            for (int n = 0; n < REG_NUM; n++) begin
                if (i2c_we && ptr_q == PW'(n))
                    bank_q[n] <= shreg_q;
                else if (apb_we && bank_hit && apb_idx == PW'(n))
                    bank_q[n] <= i_apb_pwdata[7:0];
            end
            if (i2c_we)
                wr_flag_q <= 1'b1;
            else if (apb_we && stat_hit && i_apb_pwdata[STAT_WRF_BIT])
                wr_flag_q <= 1'b0;
        end
    end

`ifdef I2C_SLAVE_IRQ_EN
    logic irq_q;
    always_ff @(posedge apb_clk or negedge apb_rstn) begin
        if (!apb_rstn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (apb_we && stat_hit) irq_en_q <= i_apb_pwdata[STAT_IRQEN_BIT];
            irq_q <= wr_flag_q & irq_en_q;
        end
    end
    assign o_irq = irq_q;
`else
    assign irq_en_q = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{i_apb_pwdata[31:8]};

endmodule
